uart_cmd_bridge: RTL and testbench

Byte-level command bridge between the UART handshake interface and an internal 32-bit memory-mapped bus. Consumes received bytes over the req/ack receive handshake, decodes fixed-length read/write/ID frames, issues one bus transaction per frame, and returns response bytes over the req/ack send handshake. It sits directly downstream of the UART receiver and upstream of the UART transmitter, making the serial port a debug/host access path into the design.

---
 rtl/uart_cmd_bridge.sv | 199 +++++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_bridge.sv
// rtl/uart_cmd_bridge.sv - UART byte-stream to 32-bit memory bus command bridge
// Decodes W/R/? frames from the receive handshake, runs one bus cycle, streams the reply back.
module uart_cmd_bridge #(
   parameter logic [7:0]  ID_BYTE        = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        uart_rec_req,
   output logic        uart_rec_ack,
   input  logic [7:0]  uart_data_out,
   output logic        uart_send_req,
   input  logic        uart_send_ack,
   output logic [7:0]  uart_data_in,
   output logic [23:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [31:0] mem_rdata,
   input  logic        mem_waitrequest
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_GET_ADDR  = 3'd1;
   localparam logic [2:0] ST_GET_DATA  = 3'd2;
   localparam logic [2:0] ST_BUS_WR    = 3'd3;
   localparam logic [2:0] ST_BUS_RD    = 3'd4;
   localparam logic [2:0] ST_SEND      = 3'd5;
   localparam logic [2:0] ST_SEND_WAIT = 3'd6;

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] OP_ID    = 8'h3F;
   localparam logic [7:0] RSP_OK   = 8'h6B;
   localparam logic [7:0] RSP_ERR  = 8'h21;

   logic [2:0]    state;
   logic [1:0]    byte_cnt;
   logic [2:0]    remain;
   logic [23:0]   rd_sh;
   logic [TW-1:0] tmo_cnt;
   logic          is_wr;
   logic          rx_state;
   logic          take;
   logic          tmo_hit;

   // Bytes are only accepted while assembling a frame; otherwise req is left pending.
   assign rx_state = (state == ST_IDLE) || (state == ST_GET_ADDR) || (state == ST_GET_DATA);
   assign take     = uart_rec_req && !uart_rec_ack && rx_state;
   assign tmo_hit  = (tmo_cnt == TMO_LAST);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= ST_IDLE;
         byte_cnt      <= '0;
         remain        <= '0;
         rd_sh         <= '0;
         tmo_cnt       <= '0;
         is_wr         <= 1'b0;
         uart_rec_ack  <= 1'b0;
         uart_send_req <= 1'b0;
         uart_data_in  <= '0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_write     <= 1'b0;
         mem_read      <= 1'b0;
      end else begin
         if (take)
            uart_rec_ack <= 1'b1;
         else if (uart_rec_ack && !uart_rec_req)
            uart_rec_ack <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (take) begin
                  tmo_cnt  <= '0;
                  byte_cnt <= '0;
                  case (uart_data_out)
                     OP_WRITE: begin
                        is_wr <= 1'b1;
                        state <= ST_GET_ADDR;
                     end
                     OP_READ: begin
                        is_wr <= 1'b0;
                        state <= ST_GET_ADDR;
                     end
                     OP_ID: begin
                        uart_data_in  <= ID_BYTE;
                        uart_send_req <= 1'b1;
                        remain        <= 3'd1;
                        state         <= ST_SEND;
                     end
                     default: begin
                        uart_data_in  <= RSP_ERR;
                        uart_send_req <= 1'b1;
                        remain        <= 3'd1;
                        state         <= ST_SEND;
                     end
                  endcase
               end
            end

            ST_GET_ADDR: begin
               if (take) begin
                  mem_addr <= {mem_addr[15:0], uart_data_out};
                  tmo_cnt  <= '0;
                  if (byte_cnt == 2'd2) begin
                     byte_cnt <= '0;
                     if (is_wr) begin
                        state <= ST_GET_DATA;
                     end else begin
                        mem_read <= 1'b1;
                        state    <= ST_BUS_RD;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end else if (tmo_hit) begin
                  tmo_cnt  <= '0;
                  byte_cnt <= '0;
                  state    <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            ST_GET_DATA: begin
               if (take) begin
                  mem_wdata <= {mem_wdata[23:0], uart_data_out};
                  tmo_cnt   <= '0;
                  if (byte_cnt == 2'd3) begin
                     byte_cnt  <= '0;
                     mem_write <= 1'b1;
                     state     <= ST_BUS_WR;
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end else if (tmo_hit) begin
                  tmo_cnt  <= '0;
                  byte_cnt <= '0;
                  state    <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            ST_BUS_WR: begin
               if (!mem_waitrequest) begin
                  mem_write     <= 1'b0;
                  uart_data_in  <= RSP_OK;
                  uart_send_req <= 1'b1;
                  remain        <= 3'd1;
                  state         <= ST_SEND;
               end
            end

            ST_BUS_RD: begin
               if (!mem_waitrequest) begin
                  mem_read      <= 1'b0;
                  uart_data_in  <= mem_rdata[31:24];
                  rd_sh         <= mem_rdata[23:0];
                  uart_send_req <= 1'b1;
                  remain        <= 3'd4;
                  state         <= ST_SEND;
               end
            end

            ST_SEND: begin
               if (uart_send_ack) begin
                  uart_send_req <= 1'b0;
                  state         <= ST_SEND_WAIT;
               end
            end

            ST_SEND_WAIT: begin
               // Next byte (or IDLE) only once the transmitter has released its ack.
               if (!uart_send_ack) begin
                  if (remain == 3'd1) begin
                     remain <= '0;
                     state  <= ST_IDLE;
                  end else begin
                     uart_data_in  <= rd_sh[23:16];
                     rd_sh         <= {rd_sh[15:0], 8'h00};
                     uart_send_req <= 1'b1;
                     remain        <= remain - 3'd1;
                     state         <= ST_SEND;
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb/tb_uart_cmd_bridge.sv - scoreboard bench for uart_cmd_bridge
// Stimulus pushes expected bus cycles and reply bytes; bus and UART-tx monitors pop and compare.
module tb_uart_cmd_bridge;

   localparam logic [7:0] ID = 8'hA5;
   localparam int LIMIT = 2000;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        uart_rec_req;
   logic        uart_rec_ack;
   logic [7:0]  uart_data_out;
   logic        uart_send_req;
   logic        uart_send_ack;
   logic [7:0]  uart_data_in;
   logic [23:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_rdata;
   logic        mem_waitrequest;

   uart_cmd_bridge #(.ID_BYTE(ID), .TIMEOUT_CYCLES(100)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .uart_rec_req(uart_rec_req), .uart_rec_ack(uart_rec_ack), .uart_data_out(uart_data_out),
      .uart_send_req(uart_send_req), .uart_send_ack(uart_send_ack), .uart_data_in(uart_data_in),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
      .mem_rdata(mem_rdata), .mem_waitrequest(mem_waitrequest)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      bit          wr;
      logic [23:0] a;
      logic [31:0] d;
   } bus_t;

   bus_t        exp_bus[$];
   logic [7:0]  exp_reply[$];
   logic [31:0] model_mem[logic [23:0]];
   logic [31:0] slave_mem[logic [23:0]];

   int total = 0;
   int bad = 0;
   int force_stall = -1;
   int tx_delay_mode = -1;
   int tx_count = 0;
   int rx_ack_txcnt = 0;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Bus slave: random stalls, memory behind it, scoreboard check on each completing cycle.
   int          stall_left, hold_cnt, exp_hold;
   bit          prev_strobe, hold_ok, expect_drop;
   logic [23:0] hold_addr;
   logic [31:0] hold_wdata;
   bus_t        eb;

   initial begin
      mem_waitrequest = 1'b0;
      mem_rdata = '0;
      prev_strobe = 1'b0;
      expect_drop = 1'b0;
   end

   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         prev_strobe = 1'b0;
         expect_drop = 1'b0;
         mem_waitrequest = 1'b0;
      end else begin
         if (expect_drop) begin
            chk("strobe_drop", {mem_read, mem_write}, 2'b00);
            expect_drop = 1'b0;
         end
         if (mem_read || mem_write) begin
            if (!prev_strobe) begin
               stall_left = (force_stall >= 0) ? force_stall : $urandom_range(0, 3);
               exp_hold   = stall_left + 1;
               hold_cnt   = 0;
               hold_addr  = mem_addr;
               hold_wdata = mem_wdata;
               hold_ok    = 1'b1;
            end
            hold_cnt++;
            if (mem_addr !== hold_addr || mem_wdata !== hold_wdata || (mem_read && mem_write))
               hold_ok = 1'b0;
            mem_rdata = slave_mem.exists(mem_addr) ? slave_mem[mem_addr] : {8'hC3, mem_addr};
            if (stall_left > 0) begin
               mem_waitrequest = 1'b1;
               stall_left--;
            end else begin
               mem_waitrequest = 1'b0;
               expect_drop = 1'b1;
               if (exp_bus.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL bus_unexpected actual=wr%0b/rd%0b addr=%h required=none",
                           mem_write, mem_read, mem_addr);
               end else begin
                  eb = exp_bus.pop_front();
                  chk("bus_kind", {mem_write, mem_read}, {eb.wr, !eb.wr});
                  chk("bus_addr", mem_addr, eb.a);
                  if (eb.wr) chk("bus_wdata", mem_wdata, eb.d);
                  chk("bus_hold_stable", hold_ok, 1'b1);
                  chk("bus_hold_len", hold_cnt, exp_hold);
               end
               if (mem_write) slave_mem[mem_addr] = mem_wdata;
            end
            prev_strobe = 1'b1;
         end else begin
            prev_strobe = 1'b0;
            mem_waitrequest = 1'b0;
         end
      end
   end

   // UART transmitter side: delayed ack, byte and stability checks.
   logic [7:0] tx_b;
   int         tx_d;
   bit         tx_stable;

   initial begin
      uart_send_ack = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (sys_rst_n && uart_send_req && !uart_send_ack) begin
            tx_b = uart_data_in;
            tx_d = (tx_delay_mode >= 0) ? tx_delay_mode : $urandom_range(0, 3);
            tx_stable = 1'b1;
            repeat (tx_d) begin
               @(negedge sys_clk);
               if (!uart_send_req || uart_data_in !== tx_b) tx_stable = 1'b0;
            end
            if (exp_reply.size() == 0) begin
               total++;
               bad++;
               $display("FAIL reply_unexpected actual=%h required=none", tx_b);
            end else begin
               chk("reply_byte", tx_b, exp_reply.pop_front());
            end
            chk("tx_stable", tx_stable, 1'b1);
            tx_count++;
            uart_send_ack = 1'b1;
            for (int i = 0; i < 100 && uart_send_req; i++) @(negedge sys_clk);
            chk("tx_req_drop", uart_send_req, 1'b0);
            uart_send_ack = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, output bit req_at_ack, output bit strobe_at_ack);
      int n;
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
      @(negedge sys_clk);
      uart_data_out = b;
      uart_rec_req = 1'b1;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!uart_rec_ack && n < LIMIT);
      if (!uart_rec_ack) begin
         total++;
         bad++;
         $display("FAIL rx_ack_timeout actual=0 required=1 byte=%h", b);
      end
      req_at_ack = uart_send_req;
      strobe_at_ack = mem_write | mem_read;
      rx_ack_txcnt = tx_count;
      uart_rec_req = 1'b0;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (uart_rec_ack && n < LIMIT);
      if (uart_rec_ack) begin
         total++;
         bad++;
         $display("FAIL rx_ack_release actual=1 required=0");
      end
   endtask

   function automatic logic [31:0] model_read(input logic [23:0] a);
      return model_mem.exists(a) ? model_mem[a] : {8'hC3, a};
   endfunction

   task automatic expect_read(input logic [23:0] a);
      logic [31:0] v;
      v = model_read(a);
      exp_bus.push_back('{1'b0, a, 32'h0});
      exp_reply.push_back(v[31:24]);
      exp_reply.push_back(v[23:16]);
      exp_reply.push_back(v[15:8]);
      exp_reply.push_back(v[7:0]);
   endtask

   task automatic do_frame(input logic [7:0] op, input logic [23:0] a, input logic [31:0] d,
                           output bit req_last, output bit strobe_last);
      logic [7:0] bytes[$];
      bytes.push_back(op);
      case (op)
         8'h57: begin
            exp_bus.push_back('{1'b1, a, d});
            model_mem[a] = d;
            exp_reply.push_back(8'h6B);
            bytes.push_back(a[23:16]); bytes.push_back(a[15:8]); bytes.push_back(a[7:0]);
            bytes.push_back(d[31:24]); bytes.push_back(d[23:16]);
            bytes.push_back(d[15:8]);  bytes.push_back(d[7:0]);
         end
         8'h52: begin
            expect_read(a);
            bytes.push_back(a[23:16]); bytes.push_back(a[15:8]); bytes.push_back(a[7:0]);
         end
         8'h3F:   exp_reply.push_back(ID);
         default: exp_reply.push_back(8'h21);
      endcase
      foreach (bytes[i]) send_byte(bytes[i], req_last, strobe_last);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_reply.size() != 0 || exp_bus.size() != 0 || uart_send_req || uart_send_ack)
             && n < 5000) begin
         @(negedge sys_clk);
         n++;
      end
      chk("drain_reply_left", exp_reply.size(), 0);
      chk("drain_bus_left", exp_bus.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   bit          rq, sb;
   int          base;
   logic [7:0]  rop;
   logic [31:0] rw;

   initial begin
      sys_rst_n = 1'b0;
      uart_rec_req = 1'b0;
      uart_data_out = '0;
      repeat (3) @(negedge sys_clk);
      chk("reset_outputs",
          {uart_rec_ack, uart_send_req, uart_data_in, mem_addr, mem_wdata, mem_write, mem_read}, '0);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      force_stall = 0;
      do_frame(8'h57, 24'h001004, 32'hDEADBEEF, rq, sb);
      chk("wr_strobe_at_capture_plus1", sb, 1'b1);
      chk("wr_req_not_before_plus2", rq, 1'b0);
      drain();

      model_mem[24'h000008] = 32'h12345678;
      slave_mem[24'h000008] = 32'h12345678;
      force_stall = 5;
      do_frame(8'h52, 24'h000008, 32'h0, rq, sb);
      drain();
      force_stall = -1;

      do_frame(8'h3F, 24'h0, 32'h0, rq, sb);
      chk("id_req_at_capture_plus1", rq, 1'b1);
      do_frame(8'h00, 24'h0, 32'h0, rq, sb);
      chk("unknown_req_at_capture_plus1", rq, 1'b1);
      drain();

      send_byte(8'h57, rq, sb);
      send_byte(8'h00, rq, sb);
      repeat (100) @(negedge sys_clk);
      do_frame(8'h3F, 24'h0, 32'h0, rq, sb);
      drain();

      expect_read(24'h000010);
      send_byte(8'h52, rq, sb);
      send_byte(8'h00, rq, sb);
      repeat (80) @(negedge sys_clk);
      send_byte(8'h00, rq, sb);
      send_byte(8'h10, rq, sb);
      drain();

      tx_delay_mode = 50;
      base = tx_count;
      do_frame(8'h52, 24'h001004, 32'h0, rq, sb);
      do_frame(8'h3F, 24'h0, 32'h0, rq, sb);
      chk("rx_held_until_idle", rx_ack_txcnt - base, 4);
      drain();
      tx_delay_mode = -1;

      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: rop = 8'h57;
            4, 5, 6:    rop = 8'h52;
            7:          rop = 8'h3F;
            default: begin
               do rop = 8'($urandom_range(0, 255));
               while (rop == 8'h57 || rop == 8'h52 || rop == 8'h3F);
            end
         endcase
         rw = $urandom;
         do_frame(rop, 24'h000100 + 24'($urandom_range(0, 15)), rw, rq, sb);
         if ($urandom_range(0, 3) == 0) drain();
      end
      drain();

      force_stall = 30;
      do_frame(8'h57, 24'h00FFF0, 32'hCAFEF00D, rq, sb);
      for (int i = 0; i < 10 && !mem_write; i++) @(negedge sys_clk);
      chk("pre_reset_write_active", mem_write, 1'b1);
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("async_reset_outputs",
          {uart_rec_ack, uart_send_req, uart_data_in, mem_addr, mem_wdata, mem_write, mem_read}, '0);
      exp_bus.delete();
      exp_reply.delete();
      model_mem.delete(24'h00FFF0);
      force_stall = -1;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      do_frame(8'h3F, 24'h0, 32'h0, rq, sb);
      drain();
      repeat (20) @(negedge sys_clk);
      chk("final_bus_queue", exp_bus.size(), 0);
      chk("final_reply_queue", exp_reply.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
